// File: rtl/ram_16x8_sync_writer_if.sv
// Write-port bundle for the 16x8 writable memory.
// The requester holds wr_addr/wr_data steady while wr_valid is high and wr_ready is low.
interface ram_16x8_sync_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ram_16x8_sync_writer.sv
// 16x8 writable memory: combinational read port (drop-in for the 16x8 ROM),
// synchronous valid/ready write port, and a block-fill engine that programs
// every word with one value.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | handshake writes accepted unless fill_start is requested
// FILL   | one word per cycle written with the latched fill value
// DONE   | single-cycle completion pulse, accepted-write count cleared
module ram_16x8_sync_writer #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_16x8_sync_writer_if.slave  wr,
    input  logic                   fill_start,
    input  logic [DATA_W-1:0]      fill_data,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             wr_count,
    input  logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      data_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
    localparam logic [4:0] COUNT_MAX = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fill_ptr;
    logic [DATA_W-1:0] fill_val;

    // Power-up content comes from the declaration; reset deliberately leaves it alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VALUE};

    logic              accept;
    logic              fill_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Next-state decode plus handshake/status outputs; also selects the single memory write source.
    always_comb begin
        state_nxt   = state;
        wr.wr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        fill_go     = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr.wr_addr;
        mem_wdata   = wr.wr_data;
        case (state)
            S_IDLE: begin
                // A fill request wins over a simultaneous write; the write stays pending.
                wr.wr_ready = !fill_start;
                accept      = wr.wr_valid && !fill_start;
                mem_we      = accept;
                if (fill_start) begin
                    fill_go   = 1'b1;
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = fill_ptr;
                mem_wdata = fill_val;
                if (fill_ptr == LAST_PTR) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill pointer and latched fill value; the pointer wraps back to 0 after word 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_ptr <= '0;
        end else if (fill_go) begin
            fill_ptr <= '0;
            fill_val <= fill_data;
        end else if (busy) begin
            fill_ptr <= fill_ptr + ADDR_W'(1);
        end
    end

    // Accepted-write counter: saturates at 31, cleared when a fill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (done) begin
            wr_count <= '0;
        end else if (accept && (wr_count != COUNT_MAX)) begin
            wr_count <= wr_count + 5'd1;
        end
    end

    // Memory write; reset blocks the write so an aborted fill stops on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = mem[address];

endmodule

// File: tb/tb_ram_16x8_sync_writer.sv
module tb_ram_16x8_sync_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fill_start;
    logic [7:0] fill_data;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
    logic [3:0] address;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    ram_16x8_sync_writer_if bus ();

    ram_16x8_sync_writer dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus),
        .fill_start (fill_start),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .address    (address),
        .data_out   (data_out)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] model [16];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } rd_t;

    rd_t exp_q[$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [4:0] exp_count;
    } wvec_t;

    wvec_t wvec [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the model contents as expected reads, then drain the queue against the read port.
    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_t r;
            r.addr = 4'(a);
            r.data = model[a];
            exp_q.push_back(r);
        end
        while (exp_q.size() > 0) begin
            rd_t r;
            r = exp_q.pop_front();
            address = r.addr;
            @(negedge clk);
            check($sformatf("%s_rd%0d", tag, r.addr), 32'(data_out), 32'(r.data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_n;
        int done_n;
        int done_at;
        int ready_bad;
        int ready_at;
        int not_ready;
        logic [4:0] sat_mid;

        wvec[0] = '{addr: 4'd3,  data: 8'h5A, exp_count: 5'd1};
        wvec[1] = '{addr: 4'd15, data: 8'hC3, exp_count: 5'd2};

        rst          = 1'b1;
        fill_start   = 1'b0;
        fill_data    = 8'h00;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 8'h00;
        address      = 4'd0;
        for (int a = 0; a < 16; a++) model[a] = 8'h00;

        // 1: power-up / reset
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check_mem("pwr");

        // 2: handshake writes, old data visible until the write edge
        for (int i = 0; i < 2; i++) begin
            tick();
            address      = wvec[i].addr;
            bus.wr_valid = 1'b1;
            bus.wr_addr  = wvec[i].addr;
            bus.wr_data  = wvec[i].data;
            @(negedge clk);
            check($sformatf("wr%0d_ready", i), 32'(bus.wr_ready), 32'd1);
            check($sformatf("wr%0d_old", i), 32'(data_out), 32'(model[wvec[i].addr]));
            tick();
            bus.wr_valid = 1'b0;
            model[wvec[i].addr] = wvec[i].data;
            check($sformatf("wr%0d_new", i), 32'(data_out), 32'(wvec[i].data));
            check($sformatf("wr%0d_count", i), 32'(wr_count), 32'(wvec[i].exp_count));
        end
        check_mem("wr");

        // 3: block fill with A5; fill_data changes during FILL must not matter
        tick();
        fill_start = 1'b1;
        fill_data  = 8'hA5;
        @(negedge clk);
        check("fill_req_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        fill_start = 1'b0;
        fill_data  = 8'h3C;
        busy_n = 0; done_n = 0; done_at = -1; ready_bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (i >= 1 && i <= 16) begin
                address = 4'(i - 1);
                @(negedge clk);
                check($sformatf("fill_live%0d", i - 1), 32'(data_out), 32'h A5);
            end else begin
                @(negedge clk);
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (bus.wr_ready && i <= 16) ready_bad++;
            tick();
        end
        check("fill_busy_cycles", 32'(busy_n), 32'd16);
        check("fill_done_cycle", 32'(done_at), 32'd16);
        check("fill_done_pulses", 32'(done_n), 32'd1);
        check("fill_ready_low", 32'(ready_bad), 32'd0);
        check("fill_count_clr", 32'(wr_count), 32'd0);
        for (int a = 0; a < 16; a++) model[a] = 8'hA5;
        check_mem("fill");

        // 4: fill_start and wr_valid collide; write waits until IDLE after DONE
        tick();
        fill_start   = 1'b1;
        fill_data    = 8'h77;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.wr_data  = 8'h11;
        @(negedge clk);
        check("coll_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        fill_start = 1'b0;
        fill_data  = 8'h00;
        ready_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                ready_at = i;
                break;
            end
            tick();
        end
        check("coll_ready_cycle", 32'(ready_at), 32'd17);
        tick();
        bus.wr_valid = 1'b0;
        for (int a = 0; a < 16; a++) model[a] = 8'h77;
        model[7] = 8'h11;
        check("coll_count", 32'(wr_count), 32'd1);
        check_mem("coll");

        // 5: reset after 5 FILL cycles aborts the fill
        tick();
        fill_start = 1'b1;
        fill_data  = 8'hFF;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(bus.wr_ready), 32'd1);
        check("abort_count", 32'(wr_count), 32'd0);
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        for (int a = 0; a < 5; a++) model[a] = 8'hFF;
        check_mem("abort");

        // 6: 33 back-to-back accepted writes, counter saturates at 31
        tick();
        bus.wr_valid = 1'b1;
        not_ready = 0;
        sat_mid = 5'd0;
        for (int i = 0; i < 33; i++) begin
            bus.wr_addr = 4'(i);
            bus.wr_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (!bus.wr_ready) not_ready++;
            if (i == 31) sat_mid = wr_count;
            model[bus.wr_addr] = bus.wr_data;
            tick();
        end
        bus.wr_valid = 1'b0;
        check("sat_ready", 32'(not_ready), 32'd0);
        check("sat_mid", 32'(sat_mid), 32'd31);
        check("sat_final", 32'(wr_count), 32'd31);
        check_mem("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
